// File: rtl/c1_pkg.sv
// Shared conv1 constants and loader state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package c1_pkg;

    localparam int C1_WD      = 8;
    localparam int C1_NW      = 25;
    localparam int C1_NUM     = 6;
    localparam int C1_NWEIGHT = C1_NW * C1_NUM;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } c1_wload_state_e;

endpackage

// File: rtl/c1_weight_loader_rd_valid_pipe.sv
// Purpose: DEPTH-deep 1-bit delay line with async active-low clear; aligns
//          the ROM read strobe with the returning ROM data.
// Latency: DEPTH cycles.  Backpressure: none, free-running shift.
// Ports: i_sclk clock, i_rstn async active-low clear, i_din strobe in,
//        o_dout strobe delayed by DEPTH cycles.
module rd_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic i_sclk,
    input  logic i_rstn,
    input  logic i_din,
    output logic o_dout
);

    logic [DEPTH-1:0] sr_q;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge i_sclk or negedge i_rstn) begin
                if (!i_rstn) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= i_din;
                end
            end
        end else begin : g_multi
            always_ff @(posedge i_sclk or negedge i_rstn) begin
                if (!i_rstn) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= {sr_q[DEPTH-2:0], i_din};
                end
            end
        end
    endgenerate

    assign o_dout = sr_q[DEPTH-1];

endmodule

// File: rtl/c1_weight_loader.sv
// Purpose: on a start pulse, read NW*NUM conv1 weights from the weight ROM and
//          emit them as one gap-free c1_weight_data/c1_weight_en burst.
// Latency: start -> done is NW*NUM + RD_LAT + 2 cycles; none back-pressure -
//          the downstream demux buffer must accept one word per cycle.
// Ports: i_sclk/i_rstn clock and async active-low reset; i_start/i_base_addr
//        load request; o_rom_rd/o_rom_addr/i_rom_data ROM read port;
//        c1_weight_data/c1_weight_en weight stream; o_busy/o_done status;
//        o_cksum weight checksum (only live when C1_WLOAD_CKSUM_EN is defined,
//        otherwise tied to 0).
// Constraints: 2**AW >= NW*NUM, RD_LAT in 1..4.
module c1_weight_loader
    import c1_pkg::*;
#(
    parameter int WD     = C1_WD,
    parameter int NW     = C1_NW,
    parameter int NUM    = C1_NUM,
    parameter int AW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic          i_sclk,
    input  logic          i_rstn,
    input  logic          i_start,
    input  logic [AW-1:0] i_base_addr,
    output logic          o_rom_rd,
    output logic [AW-1:0] o_rom_addr,
    input  logic [WD-1:0] i_rom_data,
    output logic [WD-1:0] c1_weight_data,
    output logic          c1_weight_en,
    output logic          o_busy,
    output logic          o_done,
    output logic [15:0]   o_cksum
);

    localparam int NTOT = NW * NUM;
    // One counter serves both the read index in FETCH and the drain wait.
    localparam int CW   = $clog2(NTOT + 1);

    c1_wload_state_e state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   base_q;
    logic            start_acc;
    logic            rd_vld_tail;

    // Only a start seen in IDLE is a load request; anything else is dropped.
    assign start_acc = i_start && (state_q == ST_IDLE);

    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start_acc) begin
                base_q <= i_base_addr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end
            end
            ST_FETCH: begin
                if (cnt_q == CW'(NTOT - 1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // RD_LAT+1 cycles: RD_LAT for the ROM, one for the output register.
                if (cnt_q == CW'(RD_LAT)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Address wraps modulo 2**AW by plain truncating addition.
    assign o_rom_rd   = (state_q == ST_FETCH);
    assign o_rom_addr = o_rom_rd ? (base_q + AW'(cnt_q)) : '0;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);

    rd_valid_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_valid_pipe (
        .i_sclk (i_sclk),
        .i_rstn (i_rstn),
        .i_din  (o_rom_rd),
        .o_dout (rd_vld_tail)
    );

    // Data is forced to zero outside the burst so the buffer never sees stale words.
    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            c1_weight_en   <= 1'b0;
            c1_weight_data <= '0;
        end else begin
            c1_weight_en   <= rd_vld_tail;
            c1_weight_data <= rd_vld_tail ? i_rom_data : '0;
        end
    end

`ifdef C1_WLOAD_CKSUM_EN
    logic [15:0] acc_q;
    logic [15:0] acc_nxt;
    logic [15:0] cksum_q;

    assign acc_nxt = acc_q + (c1_weight_en ? 16'(c1_weight_data) : 16'd0);

    // The last word is on the bus in the final DRAIN cycle, so the published
    // checksum takes acc_nxt rather than acc_q.
    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            acc_q   <= '0;
            cksum_q <= '0;
        end else begin
            if (start_acc) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_nxt;
            end
            if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) begin
                cksum_q <= acc_nxt;
            end
        end
    end

    assign o_cksum = cksum_q;
`else
    assign o_cksum = 16'd0;
`endif

endmodule

// File: tb/tb_c1_weight_loader.sv
module tb_c1_weight_loader;

    localparam int NI = 3;   // instance 0: RD_LAT=2, 1: RD_LAT=1, 2: RD_LAT=4
`ifdef C1_WLOAD_CKSUM_EN
    localparam logic [15:0] EXP_CKSUM = 16'd11325;
`else
    localparam logic [15:0] EXP_CKSUM = 16'd0;
`endif

    logic       clk   = 1'b0;
    logic       rstn  = 1'b1;
    logic       start = 1'b0;
    logic [7:0] base  = 8'd0;

    logic [NI-1:0]        rd, wen, busy, done;
    logic [NI-1:0][7:0]   addr, wdat;
    logic [NI-1:0][15:0]  ck;

    int checks = 0;
    int errors = 0;

    int en_first [NI];
    int en_last  [NI];
    int en_cnt   [NI];
    int gaps     [NI];
    int derr     [NI];
    int zerr     [NI];
    int done_cyc [NI];
    int done_cnt [NI];
    int busy_cnt  [NI];
    int busy_last [NI];
    int rd_cnt, rd_first, addr_err;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
            // ROM model: ROM[a] = a+1, data valid exactly L cycles after the read.
            logic [7:0] pd [4];
            logic       pv [4] = '{default: 1'b0};
            logic [7:0] rdat;
            always @(posedge clk) begin
                pv[0] <= rd[g];
                pd[0] <= addr[g] + 8'd1;
                for (int i = 1; i < 4; i++) begin
                    pv[i] <= pv[i-1];
                    pd[i] <= pd[i-1];
                end
            end
            assign rdat = pv[L-1] ? pd[L-1] : 8'hEE;

            c1_weight_loader #(
                .WD(8), .NW(25), .NUM(6), .AW(8), .RD_LAT(L)
            ) u_dut (
                .i_sclk         (clk),
                .i_rstn         (rstn),
                .i_start        (start),
                .i_base_addr    (base),
                .o_rom_rd       (rd[g]),
                .o_rom_addr     (addr[g]),
                .i_rom_data     (rdat),
                .c1_weight_data (wdat[g]),
                .c1_weight_en   (wen[g]),
                .o_busy         (busy[g]),
                .o_done         (done[g]),
                .o_cksum        (ck[g])
            );
        end
    endgenerate

    // Starts a load in the current cycle (cycle 0) and records cycles 1..ncyc.
    // Extra start pulses at cycles p1/p2 carry a different base address.
    task automatic capture(input logic [7:0] b, input int ncyc, input int p1, input int p2);
        logic [7:0] e;
        for (int i = 0; i < NI; i++) begin
            en_first[i] = -1; en_last[i] = -1; en_cnt[i] = 0; gaps[i] = 0;
            derr[i] = 0; zerr[i] = 0; done_cyc[i] = -1; done_cnt[i] = 0;
            busy_cnt[i] = 0; busy_last[i] = -1;
        end
        rd_cnt = 0; rd_first = -1; addr_err = 0;
        base  = b;
        start = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            #1;
            start = (n == p1) || (n == p2);
            base  = start ? 8'h33 : b;
            for (int i = 0; i < NI; i++) begin
                if (wen[i]) begin
                    if (en_cnt[i] == 0) en_first[i] = n;
                    else if (en_last[i] != n - 1) gaps[i]++;
                    e = b + 8'(en_cnt[i]) + 8'd1;
                    if (wdat[i] !== e) derr[i]++;
                    en_cnt[i]++;
                    en_last[i] = n;
                end else if (wdat[i] !== 8'd0) begin
                    zerr[i]++;
                end
                if (done[i]) begin
                    done_cnt[i]++;
                    done_cyc[i] = n;
                end
                if (busy[i]) begin
                    busy_cnt[i]++;
                    busy_last[i] = n;
                end
            end
            if (rd[0]) begin
                if (rd_cnt == 0) rd_first = n;
                if (addr[0] !== 8'(b + 8'(rd_cnt))) addr_err++;
                rd_cnt++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        #2;
        checks++; if (rd !== '0)   begin errors++; $display("FAIL reset_rd: got %b want 0", rd); end
        checks++; if (addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr); end
        checks++; if (wen !== '0)  begin errors++; $display("FAIL reset_en: got %b want 0", wen); end
        checks++; if (wdat !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", wdat); end
        checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== '0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (ck !== '0)   begin errors++; $display("FAIL reset_cksum: got %h want 0", ck); end
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        capture(8'd0, 170, -1, -1);
        checks++; if (en_first[0] != 4)   begin errors++; $display("FAIL basic_first_en: got %0d want 4", en_first[0]); end
        checks++; if (en_cnt[0] != 150)   begin errors++; $display("FAIL basic_en_cnt: got %0d want 150", en_cnt[0]); end
        checks++; if (gaps[0] != 0)       begin errors++; $display("FAIL basic_gaps: got %0d want 0", gaps[0]); end
        checks++; if (derr[0] != 0)       begin errors++; $display("FAIL basic_data: got %0d bad words want 0", derr[0]); end
        checks++; if (zerr[0] != 0)       begin errors++; $display("FAIL basic_idle_data: got %0d nonzero want 0", zerr[0]); end
        checks++; if (done_cyc[0] != 154) begin errors++; $display("FAIL basic_done_cyc: got %0d want 154", done_cyc[0]); end
        checks++; if (done_cnt[0] != 1)   begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt[0]); end
        checks++; if (rd_first != 1)      begin errors++; $display("FAIL basic_rd_first: got %0d want 1", rd_first); end
        checks++; if (rd_cnt != 150)      begin errors++; $display("FAIL basic_rd_cnt: got %0d want 150", rd_cnt); end
        checks++; if (addr_err != 0)      begin errors++; $display("FAIL basic_addr: got %0d bad want 0", addr_err); end
        checks++; if (busy_cnt[0] != 154) begin errors++; $display("FAIL basic_busy_cnt: got %0d want 154", busy_cnt[0]); end
        checks++; if (busy_last[0] != 154) begin errors++; $display("FAIL basic_busy_last: got %0d want 154", busy_last[0]); end
        checks++; if (ck[0] !== EXP_CKSUM) begin errors++; $display("FAIL basic_cksum: got %0d want %0d", ck[0], EXP_CKSUM); end
    endtask

    task automatic test_addr_wrap();
        capture(8'd200, 170, -1, -1);
        checks++; if (addr_err != 0)      begin errors++; $display("FAIL wrap_addr: got %0d bad want 0", addr_err); end
        checks++; if (rd_cnt != 150)      begin errors++; $display("FAIL wrap_rd_cnt: got %0d want 150", rd_cnt); end
        checks++; if (derr[0] != 0)       begin errors++; $display("FAIL wrap_data: got %0d bad want 0", derr[0]); end
        checks++; if (en_cnt[0] != 150)   begin errors++; $display("FAIL wrap_en_cnt: got %0d want 150", en_cnt[0]); end
        checks++; if (done_cyc[0] != 154) begin errors++; $display("FAIL wrap_done_cyc: got %0d want 154", done_cyc[0]); end
    endtask

    task automatic test_start_while_busy();
        capture(8'd10, 330, 50, 153);
        checks++; if (en_cnt[0] != 150)  begin errors++; $display("FAIL busy_en_cnt: got %0d want 150", en_cnt[0]); end
        checks++; if (done_cnt[0] != 1)  begin errors++; $display("FAIL busy_done_cnt: got %0d want 1", done_cnt[0]); end
        checks++; if (rd_cnt != 150)     begin errors++; $display("FAIL busy_rd_cnt: got %0d want 150", rd_cnt); end
        checks++; if (addr_err != 0)     begin errors++; $display("FAIL busy_addr: got %0d bad want 0", addr_err); end
        checks++; if (derr[0] != 0)      begin errors++; $display("FAIL busy_data: got %0d bad want 0", derr[0]); end
        // For RD_LAT=1 the cycle-153 pulse lands exactly in the DONE cycle.
        checks++; if (done_cnt[1] != 1)  begin errors++; $display("FAIL busy_done_in_done: got %0d want 1", done_cnt[1]); end
        checks++; if (en_cnt[1] != 150)  begin errors++; $display("FAIL busy_en_cnt_l1: got %0d want 150", en_cnt[1]); end
    endtask

    task automatic test_latency_sweep();
        capture(8'd0, 170, -1, -1);
        checks++; if (en_first[1] != 3)   begin errors++; $display("FAIL lat1_first_en: got %0d want 3", en_first[1]); end
        checks++; if (done_cyc[1] != 153) begin errors++; $display("FAIL lat1_done_cyc: got %0d want 153", done_cyc[1]); end
        checks++; if (gaps[1] != 0 || en_cnt[1] != 150) begin errors++; $display("FAIL lat1_burst: got gaps %0d cnt %0d want 0/150", gaps[1], en_cnt[1]); end
        checks++; if (derr[1] != 0)       begin errors++; $display("FAIL lat1_data: got %0d bad want 0", derr[1]); end
        checks++; if (en_first[2] != 6)   begin errors++; $display("FAIL lat4_first_en: got %0d want 6", en_first[2]); end
        checks++; if (done_cyc[2] != 156) begin errors++; $display("FAIL lat4_done_cyc: got %0d want 156", done_cyc[2]); end
        checks++; if (gaps[2] != 0 || en_cnt[2] != 150) begin errors++; $display("FAIL lat4_burst: got gaps %0d cnt %0d want 0/150", gaps[2], en_cnt[2]); end
        checks++; if (derr[2] != 0)       begin errors++; $display("FAIL lat4_data: got %0d bad want 0", derr[2]); end
    endtask

    task automatic test_mid_reset();
        int dcnt;
        base  = 8'd0;
        start = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rstn = 1'b0;
        #1;
        checks++; if (rd !== '0)   begin errors++; $display("FAIL mreset_rd: got %b want 0", rd); end
        checks++; if (addr !== '0) begin errors++; $display("FAIL mreset_addr: got %h want 0", addr); end
        checks++; if (wen !== '0)  begin errors++; $display("FAIL mreset_en: got %b want 0", wen); end
        checks++; if (wdat !== '0) begin errors++; $display("FAIL mreset_data: got %h want 0", wdat); end
        checks++; if (busy !== '0) begin errors++; $display("FAIL mreset_busy: got %b want 0", busy); end
        checks++; if (done !== '0) begin errors++; $display("FAIL mreset_done: got %b want 0", done); end
        dcnt = 0;
        for (int n = 81; n <= 260; n++) begin
            @(posedge clk);
            #1;
            if (n == 83) rstn = 1'b1;
            if (|done || |wen) dcnt++;
        end
        checks++; if (dcnt != 0) begin errors++; $display("FAIL mreset_no_done: got %0d active cycles want 0", dcnt); end
        capture(8'd0, 170, -1, -1);
        checks++; if (en_cnt[0] != 150 || gaps[0] != 0) begin errors++; $display("FAIL mreset_reload_burst: got cnt %0d gaps %0d want 150/0", en_cnt[0], gaps[0]); end
        checks++; if (en_first[0] != 4)   begin errors++; $display("FAIL mreset_reload_first: got %0d want 4", en_first[0]); end
        checks++; if (derr[0] != 0 || derr[2] != 0) begin errors++; $display("FAIL mreset_reload_data: got %0d/%0d bad want 0", derr[0], derr[2]); end
        checks++; if (done_cyc[0] != 154) begin errors++; $display("FAIL mreset_reload_done: got %0d want 154", done_cyc[0]); end
        checks++; if (ck[0] !== EXP_CKSUM) begin errors++; $display("FAIL mreset_reload_cksum: got %0d want %0d", ck[0], EXP_CKSUM); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_addr_wrap();
        test_start_while_busy();
        test_latency_sweep();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
